sr_button_conditioner: RTL

//  Upstream input stage for the EGO1 RS flip-flop experiment. Takes raw S and R

---
 rtl/sr_button_conditioner.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sr_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module : sr_button_conditioner (+ sr_debounce_channel)
// Brief  : sync + counter debounce of raw S/R pads, mutually exclusive S/R drive
// Rev    : 1.0
// ============================================================================

module sr_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_st_stable_lo = 2'd0;
  localparam logic [1:0] c_st_pend_hi   = 2'd1;
  localparam logic [1:0] c_st_stable_hi = 2'd2;
  localparam logic [1:0] c_st_pend_lo   = 2'd3;

  logic             sync1_q;
  logic             sync_q;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             w_level;

  // The accepted level is encoded in the state: high while stable-high or
  // while a pending fall has not yet been confirmed.
  assign w_level = (state_q == c_st_stable_hi) || (state_q == c_st_pend_lo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync_q == w_level) begin
      cnt_d   = '0;
      state_d = w_level ? c_st_stable_hi : c_st_stable_lo;
    end else if (cnt_q == c_cnt_last) begin
      cnt_d   = '0;
      state_d = sync_q ? c_st_stable_hi : c_st_stable_lo;
      pulse_d = sync_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = sync_q ? c_st_pend_hi : c_st_pend_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_stable_lo;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = w_level;
  assign pulse_o = pulse_q;

endmodule

module sr_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int PRIORITY        = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_s,
  input  logic btn_r,
  output logic s_level,
  output logic r_level,
  output logic s_pulse,
  output logic r_pulse,
  output logic s_out,
  output logic r_out,
  output logic conflict
);

  logic [1:0] w_pad;
  logic [1:0] w_level;
  logic [1:0] w_pulse;
  logic       s_out_q;
  logic       s_out_d;
  logic       r_out_q;
  logic       r_out_d;

  assign w_pad = {btn_r, btn_s};

  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      sr_debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .pad_i  (w_pad[ch]),
        .level_o(w_level[ch]),
        .pulse_o(w_pulse[ch])
      );
    end
  endgenerate

  // Both levels high is the forbidden latch input; unknown PRIORITY values
  // fall back to driving neither side so the latch simply holds.
  always_comb begin
    s_out_d = w_level[0];
    r_out_d = w_level[1];
    if (w_level[0] && w_level[1]) begin
      s_out_d = (PRIORITY == 1);
      r_out_d = (PRIORITY == 2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_out_q <= 1'b0;
      r_out_q <= 1'b0;
    end else begin
      s_out_q <= s_out_d;
      r_out_q <= r_out_d;
    end
  end

  assign s_level  = w_level[0];
  assign r_level  = w_level[1];
  assign s_pulse  = w_pulse[0];
  assign r_pulse  = w_pulse[1];
  assign s_out    = s_out_q;
  assign r_out    = r_out_q;
  assign conflict = w_level[0] & w_level[1];

endmodule

`default_nettype wire
